debounce_d: RTL and testbench

Input conditioner placed directly upstream of the D latch. It takes a raw, asynchronous, bouncy switch or button level and resynchronizes it to `clk`. It then filters it with a counter-based stability check and drives a clean, glitch-free level pair `q`/`nq` that can feed the latch `d` input directly. Optional single-cycle edge pulses report accepted transitions.

---
 rtl/debounce_d_if.sv | 25 ++
 rtl/debounce_d.sv | 131 +++++++++++++
 tb/tb_debounce_d.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/debounce_d_if.sv
// Signal bundle between a raw switch source and the debounce_d conditioner.
// The conditioner uses the slave modport; whoever drives btn uses master.
interface debounce_d_if;
    logic btn;
    logic q;
    logic nq;
    logic rise;
    logic fall;

    modport master (
        output btn,
        input  q,
        input  nq,
        input  rise,
        input  fall
    );

    modport slave (
        input  btn,
        output q,
        output nq,
        output rise,
        output fall
    );
endinterface

// File: rtl/debounce_d.sv
// Switch debouncer: 2-flop synchronizer, then a counter-qualified FSM driving registered q/nq.
// Edge pulses rise/fall are built only when DEBOUNCE_EDGE_PULSE_EN is defined.
module debounce_d #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    debounce_d_if.slave  bus
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_TERM = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    logic          s1_reg;
    logic          s_reg;
    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          q_reg;
    logic          nq_reg;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic          rise_reg;
    logic          fall_reg;
`endif

    // btn is asynchronous; only s_reg is allowed to reach the filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg <= 1'b0;
            s_reg  <= 1'b0;
        end else begin
            s1_reg <= bus.btn;
            s_reg  <= s1_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LOW;
            cnt_reg   <= '0;
            q_reg     <= 1'b0;
            nq_reg    <= 1'b1;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
`endif
        end else begin
`ifdef DEBOUNCE_EDGE_PULSE_EN
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
`endif
            case (state_reg)
                LOW: begin
                    if (s_reg) begin
                        state_reg <= RISE_WAIT;
                        cnt_reg   <= CNT_ONE;
                    end else begin
                        cnt_reg   <= '0;
                    end
                end
                RISE_WAIT: begin
                    // An opposing sample wins over the terminal count.
                    if (!s_reg) begin
                        state_reg <= LOW;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_TERM) begin
                        state_reg <= HIGH;
                        cnt_reg   <= '0;
                        q_reg     <= 1'b1;
                        nq_reg    <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
                        rise_reg  <= 1'b1;
`endif
                    end else begin
                        cnt_reg   <= cnt_reg + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!s_reg) begin
                        state_reg <= FALL_WAIT;
                        cnt_reg   <= CNT_ONE;
                    end else begin
                        cnt_reg   <= '0;
                    end
                end
                FALL_WAIT: begin
                    if (s_reg) begin
                        state_reg <= HIGH;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_TERM) begin
                        state_reg <= LOW;
                        cnt_reg   <= '0;
                        q_reg     <= 1'b0;
                        nq_reg    <= 1'b1;
`ifdef DEBOUNCE_EDGE_PULSE_EN
                        fall_reg  <= 1'b1;
`endif
                    end else begin
                        cnt_reg   <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= LOW;
                    cnt_reg   <= '0;
                    q_reg     <= 1'b0;
                    nq_reg    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.q  = q_reg;
    assign bus.nq = nq_reg;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    assign bus.rise = rise_reg;
    assign bus.fall = fall_reg;
`else
    assign bus.rise = 1'b0;
    assign bus.fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_d.sv
// Directed bench for debounce_d (STABLE_CYCLES=4); pulse expectations follow DEBOUNCE_EDGE_PULSE_EN.
module tb_debounce_d;

    localparam int NEVER = 1000;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    localparam logic EXP_PULSE = 1'b1;
`else
    localparam logic EXP_PULSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_seen = 0;
    int   fall_seen = 0;

    always #5 clk = ~clk;

    debounce_d_if bus ();

    debounce_d #(.STABLE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        rise_seen += int'(bus.rise);
        fall_seen += int'(bus.fall);
    endtask

    // n edges; q is expected to flip away from q0 on relative edge flip_at.
    task automatic watch(input string tag, input int n, input int flip_at, input logic q0);
        logic qe;
        logic re;
        logic fe;
        for (int i = 1; i <= n; i++) begin
            tick();
            qe = (i >= flip_at) ? !q0 : q0;
            re = (i == flip_at && !q0) ? EXP_PULSE : 1'b0;
            fe = (i == flip_at &&  q0) ? EXP_PULSE : 1'b0;
            check({tag, " q"},    32'(bus.q),    32'(qe));
            check({tag, " nq"},   32'(bus.nq),   32'(!qe));
            check({tag, " rise"}, 32'(bus.rise), 32'(re));
            check({tag, " fall"}, 32'(bus.fall), 32'(fe));
        end
    endtask

    initial begin
        int r0;
        int f0;
        logic [8:0] pat;

        // Reset held with btn high: outputs pinned at reset values.
        rst = 1'b1;
        bus.btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset outs", 32'({bus.q, bus.nq, bus.rise, bus.fall}), 32'(4'b0100));
            check("reset cnt", 32'(dut.cnt_reg), 32'd0);
        end
        rst = 1'b0;
        r0 = rise_seen;
        watch("rst_release", 8, 6, 1'b0);
        check("rst_release rise count", 32'(rise_seen - r0), 32'(EXP_PULSE));

        // Clean press/release.
        bus.btn = 1'b0;
        watch("prep_low", 8, 6, 1'b1);
        r0 = rise_seen;
        f0 = fall_seen;
        bus.btn = 1'b1;
        watch("press", 10, 6, 1'b0);
        bus.btn = 1'b0;
        watch("release", 10, 6, 1'b1);
        check("press rise count", 32'(rise_seen - r0), 32'(EXP_PULSE));
        check("press fall count", 32'(fall_seen - f0), 32'(EXP_PULSE));

        // 3-sample glitch rejected, 4-sample glitch accepted.
        r0 = rise_seen;
        bus.btn = 1'b1;
        watch("glitch3_hi", 3, NEVER, 1'b0);
        bus.btn = 1'b0;
        watch("glitch3_lo", 8, NEVER, 1'b0);
        check("glitch3 rise count", 32'(rise_seen - r0), 32'd0);
        r0 = rise_seen;
        bus.btn = 1'b1;
        watch("glitch4_hi", 4, NEVER, 1'b0);
        bus.btn = 1'b0;
        watch("glitch4_lo_a", 3, 2, 1'b0);
        watch("glitch4_lo_b", 8, 3, 1'b1);
        check("glitch4 rise count", 32'(rise_seen - r0), 32'(EXP_PULSE));

        // Bounce burst 1,0,1,1,0,1,1,1,1: accepted on relative edge 11.
        r0 = rise_seen;
        pat = 9'b111101101;
        for (int j = 0; j < 9; j++) begin
            bus.btn = pat[j];
            tick();
            check("burst q", 32'(bus.q), 32'd0);
        end
        watch("burst_hold", 4, 2, 1'b0);
        check("burst rise count", 32'(rise_seen - r0), 32'(EXP_PULSE));

        // Reset in RISE_WAIT with cnt=2.
        bus.btn = 1'b0;
        watch("back_low", 8, 6, 1'b1);
        bus.btn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("midwait cnt", 32'(dut.cnt_reg), 32'd2);
        check("midwait q", 32'(bus.q), 32'd0);
        rst = 1'b1;
        #1;
        check("async rst cnt", 32'(dut.cnt_reg), 32'd0);
        check("async rst outs", 32'({bus.q, bus.nq, bus.rise, bus.fall}), 32'(4'b0100));
        tick();
        tick();
        check("rst held outs", 32'({bus.q, bus.nq, bus.rise, bus.fall}), 32'(4'b0100));
        rst = 1'b0;
        watch("post_rst", 8, 6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
